// File: rtl/updi_prog_sequencer.sv
// Top-level UPDI programming sequencer: break, unlock, ID check, block programming.
// Define UPDI_PROG_SEQ_VERIFY_EN to add a read-back verify pass after every block write.
module updi_prog_sequencer #(
    parameter int          ADDR_BITS          = 16,
    parameter int          LEN_BITS           = 7,
    parameter int          MAX_RETRIES        = 3,
    parameter int          TIMEOUT_CLK        = 200000,
    parameter int          POLL_LIMIT         = 64,
    parameter logic [23:0] EXPECTED_DEVICE_ID = 24'h000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           error_code,
    output logic                 break_start,
    input  logic                 break_busy,
    output logic                 cmd_valid,
    output logic [3:0]           cmd_op,
    output logic [ADDR_BITS-1:0] cmd_addr,
    output logic [LEN_BITS-1:0]  cmd_len,
    input  logic                 cmd_ready,
    input  logic                 cmd_done,
    input  logic                 cmd_ack_error,
    input  logic [7:0]           rsp_data,
    input  logic                 rsp_valid,
    output logic                 blk_start,
    input  logic                 blk_ready,
    input  logic                 blk_last,
    input  logic [ADDR_BITS-1:0] blk_addr,
    input  logic [LEN_BITS-1:0]  blk_len,
    output logic [LEN_BITS-1:0]  blk_idx,
    input  logic [7:0]           blk_byte
);
    localparam int TW = $clog2(TIMEOUT_CLK + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [4:0] {
        S_IDLE, S_BREAK, S_BREAK_WAIT, S_STATUS,
        S_ERASE_KEY, S_ERASE_RST, S_ERASE_REL, S_ERASE_POLL,
        S_NVM_KEY, S_NVM_RST, S_NVM_REL, S_NVM_POLL,
        S_ID, S_FETCH, S_FETCH_WAIT, S_WRITE, S_VERIFY,
        S_FIN_RST, S_FIN_REL, S_DONE, S_ERROR
    } state_t;

    state_t                state_reg;
    logic                  wait_reg;
    logic [TW-1:0]         timer_reg;
    logic [RW-1:0]         retry_reg;
    logic [PW-1:0]         poll_reg;
    logic [7:0]            status_reg;
    logic [23:0]           id_reg;
    logic                  mismatch_reg;
    logic                  busy_reg, done_reg, error_reg, break_reg, valid_reg, blk_start_reg;
    logic [2:0]            code_reg;
    logic [3:0]            op_reg;
    logic [ADDR_BITS-1:0]  addr_reg;
    logic [LEN_BITS-1:0]   len_reg, idx_reg;

    logic                  is_cmd, cmd_ok, cmd_nak, cmd_tmo, bad_now;
    logic [3:0]            state_op;
    logic [7:0]            last_byte;
    logic [23:0]           id_now;
    logic [2:0]            fail_code;

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign error       = error_reg;
    assign error_code  = code_reg;
    assign break_start = break_reg;
    assign cmd_valid   = valid_reg;
    assign cmd_op      = op_reg;
    assign cmd_addr    = addr_reg;
    assign cmd_len     = len_reg;
    assign blk_start   = blk_start_reg;
    assign blk_idx     = idx_reg;

    // A response byte arriving together with cmd_done must still count.
    assign last_byte = rsp_valid ? rsp_data : status_reg;
    assign id_now    = rsp_valid ? {id_reg[15:0], rsp_data} : id_reg;
    assign bad_now   = rsp_valid && (rsp_data != blk_byte);
    assign cmd_ok    = wait_reg && cmd_done && !cmd_ack_error;
    assign cmd_nak   = wait_reg && cmd_done && cmd_ack_error;
    assign cmd_tmo   = wait_reg && !cmd_done && (timer_reg == TW'(TIMEOUT_CLK - 1));

    always_comb begin
        is_cmd   = 1'b1;
        state_op = 4'd0;
        case (state_reg)
            S_STATUS:                       state_op = 4'd0;
            S_ERASE_POLL, S_NVM_POLL:       state_op = 4'd1;
            S_ERASE_KEY:                    state_op = 4'd2;
            S_NVM_KEY:                      state_op = 4'd3;
            S_ERASE_RST, S_NVM_RST, S_FIN_RST: state_op = 4'd4;
            S_ERASE_REL, S_NVM_REL, S_FIN_REL: state_op = 4'd5;
            S_ID:                           state_op = 4'd6;
            S_WRITE:                        state_op = 4'd7;
            S_VERIFY:                       state_op = 4'd8;
            default:                        is_cmd = 1'b0;
        endcase
    end

    always_comb begin
        fail_code = 3'd0;
        if (is_cmd && (cmd_nak || cmd_tmo) && (retry_reg == RW'(MAX_RETRIES))) begin
            fail_code = cmd_nak ? 3'd2 : 3'd3;
        end else if (is_cmd && cmd_ok) begin
            case (state_reg)
                S_STATUS:     if (last_byte == 8'h00) fail_code = 3'd1;
                S_ERASE_POLL: if (last_byte[0] && (poll_reg == PW'(POLL_LIMIT - 1))) fail_code = 3'd4;
                S_NVM_POLL:   if (!last_byte[3] && (poll_reg == PW'(POLL_LIMIT - 1))) fail_code = 3'd5;
                S_ID:         if ((EXPECTED_DEVICE_ID != 24'd0) && (id_now != EXPECTED_DEVICE_ID)) fail_code = 3'd7;
                S_VERIFY:     if (mismatch_reg || bad_now) fail_code = 3'd6;
                default:      fail_code = 3'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;    wait_reg <= 1'b0;     timer_reg <= '0;
            retry_reg <= '0;        poll_reg <= '0;       status_reg <= '0;
            id_reg <= '0;           mismatch_reg <= 1'b0; busy_reg <= 1'b0;
            done_reg <= 1'b0;       error_reg <= 1'b0;    break_reg <= 1'b0;
            valid_reg <= 1'b0;      blk_start_reg <= 1'b0; code_reg <= '0;
            op_reg <= '0;           addr_reg <= '0;       len_reg <= '0;
            idx_reg <= '0;
        end else begin
            done_reg      <= 1'b0;
            break_reg     <= 1'b0;
            blk_start_reg <= 1'b0;
            if (fail_code != 3'd0) begin
                state_reg <= S_ERROR;
                error_reg <= 1'b1;
                code_reg  <= fail_code;
                busy_reg  <= 1'b0;
                valid_reg <= 1'b0;
                wait_reg  <= 1'b0;
            end else if (is_cmd) begin
                if (!wait_reg) begin
                    if (!valid_reg) begin
                        valid_reg <= 1'b1;
                        op_reg    <= state_op;
                    end else if (cmd_ready) begin
                        valid_reg <= 1'b0;
                        wait_reg  <= 1'b1;
                        timer_reg <= '0;
                    end
                end else begin
                    timer_reg <= timer_reg + TW'(1);
                    if (rsp_valid) begin
                        case (state_reg)
                            S_STATUS, S_ERASE_POLL, S_NVM_POLL: status_reg <= rsp_data;
                            S_ID:     id_reg <= id_now;
                            S_WRITE:  idx_reg <= idx_reg + LEN_BITS'(1);
                            S_VERIFY: begin
                                idx_reg <= idx_reg + LEN_BITS'(1);
                                if (bad_now) mismatch_reg <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    if (cmd_nak || cmd_tmo) begin
                        // Same op_reg is re-presented immediately.
                        wait_reg  <= 1'b0;
                        valid_reg <= 1'b1;
                        retry_reg <= retry_reg + RW'(1);
                    end else if (cmd_ok) begin
                        wait_reg  <= 1'b0;
                        retry_reg <= '0;
                        case (state_reg)
                            S_STATUS:    state_reg <= S_ERASE_KEY;
                            S_ERASE_KEY: state_reg <= S_ERASE_RST;
                            S_ERASE_RST: state_reg <= S_ERASE_REL;
                            S_ERASE_REL: begin state_reg <= S_ERASE_POLL; poll_reg <= '0; end
                            S_ERASE_POLL:
                                if (!last_byte[0]) state_reg <= S_NVM_KEY;
                                else begin poll_reg <= poll_reg + PW'(1); valid_reg <= 1'b1; end
                            S_NVM_KEY:   state_reg <= S_NVM_RST;
                            S_NVM_RST:   state_reg <= S_NVM_REL;
                            S_NVM_REL:   begin state_reg <= S_NVM_POLL; poll_reg <= '0; end
                            S_NVM_POLL:
                                if (last_byte[3]) state_reg <= S_ID;
                                else begin poll_reg <= poll_reg + PW'(1); valid_reg <= 1'b1; end
                            S_ID:        state_reg <= S_FETCH;
`ifdef UPDI_PROG_SEQ_VERIFY_EN
                            S_WRITE:     begin state_reg <= S_VERIFY; idx_reg <= '0; mismatch_reg <= 1'b0; end
`else
                            S_WRITE:     state_reg <= S_FETCH;
`endif
                            S_VERIFY:    state_reg <= S_FETCH;
                            S_FIN_RST:   state_reg <= S_FIN_REL;
                            S_FIN_REL:   begin state_reg <= S_DONE; done_reg <= 1'b1; busy_reg <= 1'b0; end
                            default:     state_reg <= S_ERROR;
                        endcase
                    end
                end
            end else begin
                case (state_reg)
                    S_IDLE, S_DONE, S_ERROR:
                        if (start) begin
                            state_reg <= S_BREAK;
                            busy_reg  <= 1'b1;
                            error_reg <= 1'b0;
                            code_reg  <= '0;
                            break_reg <= 1'b1;
                            retry_reg <= '0;
                        end else if (state_reg == S_DONE) begin
                            state_reg <= S_IDLE;
                        end
                    // The break block raises break_busy the cycle after the pulse.
                    S_BREAK:      state_reg <= S_BREAK_WAIT;
                    S_BREAK_WAIT: if (!break_busy) state_reg <= S_STATUS;
                    S_FETCH: begin
                        blk_start_reg <= 1'b1;
                        state_reg     <= S_FETCH_WAIT;
                    end
                    S_FETCH_WAIT:
                        if (blk_ready) begin
                            if (blk_last) state_reg <= S_FIN_RST;
                            else if (blk_len == '0) state_reg <= S_FETCH;
                            else begin
                                addr_reg  <= blk_addr;
                                len_reg   <= blk_len;
                                idx_reg   <= '0;
                                state_reg <= S_WRITE;
                            end
                        end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_updi_prog_sequencer.sv
// Directed bench for updi_prog_sequencer with behavioural break block, UPDI engine and block ROM.
`define CHK(tag, obs, exp) begin n_chk++; assert ((obs) === (exp)) n_pass++; else begin n_fail++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_updi_prog_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, break_busy, cmd_ready, cmd_done, cmd_ack_error, rsp_valid;
    logic        blk_ready, blk_last;
    logic [7:0]  rsp_data, blk_byte;
    logic [15:0] cmd_addr, blk_addr;
    logic [6:0]  cmd_len, blk_len, blk_idx;
    logic [3:0]  cmd_op;
    logic [2:0]  error_code;
    logic        busy, done, error, break_start, cmd_valid, blk_start;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    // Scenario configuration, written only by the stimulus block.
    logic [7:0]  status_val = 8'h30;
    logic        status_hang = 1'b0;
    int          erase_clear_at = 2, nvm_set_at = 1, nvm_fail_n = 0;
    logic [23:0] id_val = 24'h1E9123;
    logic        corrupt = 1'b0;

    updi_prog_sequencer #(
        .ADDR_BITS(16), .LEN_BITS(7), .MAX_RETRIES(3), .TIMEOUT_CLK(100),
        .POLL_LIMIT(8), .EXPECTED_DEVICE_ID(24'h1E9123)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .error_code(error_code), .break_start(break_start), .break_busy(break_busy),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_ack_error(cmd_ack_error),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .blk_start(blk_start),
        .blk_ready(blk_ready), .blk_last(blk_last), .blk_addr(blk_addr), .blk_len(blk_len),
        .blk_idx(blk_idx), .blk_byte(blk_byte)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [15:0] a, input logic [6:0] i);
        return 8'h0D + a[7:0] + {1'b0, i};
    endfunction
    assign blk_byte = rom(blk_addr, blk_idx);

    // Monitor: accept counts per op, op-0 accept times, pulse counts.
    int op_cnt[16];
    int op0_t[64];
    int op0_n = 0, brk_cnt = 0, done_cnt = 0, cyc = 0;
    initial begin
        for (int i = 0; i < 16; i++) op_cnt[i] = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && cmd_valid && cmd_ready) begin
                op_cnt[cmd_op]++;
                if (cmd_op == 4'd0) begin
                    if (op0_n < 64) op0_t[op0_n] = cyc;
                    op0_n++;
                end
            end
            if (break_start) brk_cnt++;
            if (done) done_cnt++;
        end
    end

    // Double-break block: busy from the cycle after the pulse for 10 cycles.
    initial begin
        int bb;
        bb = 0;
        break_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin break_busy = 1'b0; bb = 0; end
            else if (break_start) begin break_busy = 1'b1; bb = 10; end
            else if (bb > 0) begin bb--; if (bb == 0) break_busy = 1'b0; end
        end
    end

    // Block ROM: 0x0000/64, a zero-length block, 0x0040/10, then last.
    initial begin
        int bn;
        bn = 0;
        blk_ready = 1'b0; blk_last = 1'b0; blk_addr = '0; blk_len = '0;
        forever begin
            @(negedge clk);
            if (rst) begin blk_ready = 1'b0; continue; end
            if (break_start) bn = 0;
            if (blk_start) begin
                blk_ready = 1'b1;
                case (bn)
                    0: begin blk_addr = 16'h0000; blk_len = 7'd64; blk_last = 1'b0; end
                    1: begin blk_addr = 16'h0080; blk_len = 7'd0;  blk_last = 1'b0; end
                    2: begin blk_addr = 16'h0040; blk_len = 7'd10; blk_last = 1'b0; end
                    default: begin blk_len = 7'd0; blk_last = 1'b1; end
                endcase
                bn++;
            end else begin
                blk_ready = 1'b0;
            end
        end
    end

    // Command engine model.
    int key_phase = 0, ep = 0, np = 0, n3 = 0, wr_n = 0, v_n = 0, wr_errs = 0, op8_done_cnt = 0;
    logic [15:0] w_addr[4];
    logic [6:0]  w_len[4];

    task automatic serve(input logic [3:0] op, input logic [15:0] a, input logic [6:0] n);
        int cnt;
        logic ae;
        logic [7:0] pb;
        cnt = 0; ae = 1'b0; pb = 8'h00;
        case (op)
            4'd0: begin if (status_hang) return; cnt = 1; end
            4'd1: begin
                cnt = 1;
                if (key_phase == 2) begin ep++; pb = (ep >= erase_clear_at) ? 8'h00 : 8'h01; end
                else begin np++; pb = (np >= nvm_set_at) ? 8'h08 : 8'h00; end
            end
            4'd2: key_phase = 2;
            4'd3: begin key_phase = 3; n3++; ae = (n3 <= nvm_fail_n); end
            4'd6: cnt = 3;
            4'd7: begin cnt = int'(n); if (wr_n < 4) begin w_addr[wr_n] = a; w_len[wr_n] = n; end wr_n++; end
            4'd8: begin cnt = int'(n); v_n++; end
            default: cnt = 0;
        endcase
        for (int i = 0; i < cnt; i++) begin
            case (op)
                4'd0: rsp_data = status_val;
                4'd1: rsp_data = pb;
                4'd6: rsp_data = (i == 0) ? id_val[23:16] : (i == 1) ? id_val[15:8] : id_val[7:0];
                4'd8: rsp_data = (corrupt && v_n == 1 && i == 5) ? 8'hFF : rom(a, 7'(i));
                default: rsp_data = 8'h00;
            endcase
            if (op == 4'd7 && (blk_idx != 7'(i) || blk_byte != rom(a, 7'(i)))) wr_errs++;
            rsp_valid = 1'b1;
            @(negedge clk);
            if (rst) begin rsp_valid = 1'b0; return; end
        end
        rsp_valid = 1'b0;
        cmd_done = 1'b1;
        cmd_ack_error = ae;
        if (op == 4'd8) op8_done_cnt++;
        @(negedge clk);
        cmd_done = 1'b0;
        cmd_ack_error = 1'b0;
    endtask

    initial begin
        cmd_ready = 1'b0; cmd_done = 1'b0; cmd_ack_error = 1'b0; rsp_valid = 1'b0; rsp_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin cmd_ready = 1'b0; continue; end
            if (break_start) begin ep = 0; np = 0; n3 = 0; wr_n = 0; v_n = 0; end
            if (cmd_ready) begin
                cmd_ready = 1'b0;
                serve(cmd_op, cmd_addr, cmd_len);
            end else if (cmd_valid) begin
                cmd_ready = 1'b1;
            end
        end
    end

    // Stimulus and checks.
    int b_op[16];
    int b_brk, b_done, b_o8d, b_op0n;
    logic got_done, got_err, busy_at_end;
    int gaps;

    task automatic snap();
        for (int i = 0; i < 16; i++) b_op[i] = op_cnt[i];
        b_brk = brk_cnt; b_done = done_cnt; b_o8d = op8_done_cnt; b_op0n = op0_n;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        got_done = 1'b0; got_err = 1'b0; gaps = 0; busy_at_end = 1'b1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done || error) begin
                got_done = done; got_err = error; busy_at_end = busy;
                return;
            end
            if (!busy) gaps++;
        end
        `CHK("end_bound", 1'b0, 1'b1)
    endtask

    initial begin
        int mn;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_flags", {done, error, break_start, cmd_valid, blk_start}, 5'b0)
        `CHK("rst_vals", {error_code, cmd_op, cmd_addr, cmd_len, blk_idx}, 37'd0)
        rst = 1'b0;
        @(negedge clk);
        `CHK("idle_busy", busy, 1'b0)

        // Nominal run with an ignored start while busy.
        snap();
        pulse_start();
        `CHK("nom_busy_rise", busy, 1'b1)
        repeat (20) @(negedge clk);
        pulse_start();
        wait_end(3000);
        `CHK("nom_done", got_done, 1'b1)
        `CHK("nom_err", got_err, 1'b0)
        `CHK("nom_busy_gaps", gaps, 0)
        `CHK("nom_busy_at_done", busy_at_end, 1'b0)
        `CHK("nom_breaks", brk_cnt - b_brk, 1)
        `CHK("nom_polls", op_cnt[1] - b_op[1], 3)
        `CHK("nom_id_reads", op_cnt[6] - b_op[6], 1)
        `CHK("nom_writes", op_cnt[7] - b_op[7], 2)
        `CHK("nom_blk0", {w_addr[0], w_len[0]}, {16'h0000, 7'd64})
        `CHK("nom_blk1", {w_addr[1], w_len[1]}, {16'h0040, 7'd10})
        `CHK("nom_wr_data", wr_errs, 0)
`ifdef UPDI_PROG_SEQ_VERIFY_EN
        `CHK("nom_verifies", op_cnt[8] - b_op[8], 2)
`else
        `CHK("nom_no_verify", op_cnt[8] - b_op[8], 0)
`endif
        @(negedge clk);
        `CHK("nom_done_width", done, 1'b0)
        `CHK("nom_done_count", done_cnt - b_done, 1)

        // Two NAKs on KEY_NVMPROG are absorbed by retries.
        nvm_fail_n = 2;
        snap();
        pulse_start();
        wait_end(3000);
        `CHK("ack2_done", got_done, 1'b1)
        `CHK("ack2_key_tries", op_cnt[3] - b_op[3], 3)

        // Four NAKs exhaust the retries.
        nvm_fail_n = 4;
        snap();
        pulse_start();
        wait_end(3000);
        `CHK("ack4_err", {got_err, error_code}, {1'b1, 3'd2})
        `CHK("ack4_key_tries", op_cnt[3] - b_op[3], 4)
        `CHK("ack4_busy", busy, 1'b0)
        nvm_fail_n = 0;

        // Status command never completes.
        status_hang = 1'b1;
        snap();
        pulse_start();
        `CHK("err_cleared", error, 1'b0)
        wait_end(1500);
        `CHK("tmo_err", {got_err, error_code}, {1'b1, 3'd3})
        `CHK("tmo_accepts", op0_n - b_op0n, 4)
        mn = 100000;
        for (int i = 1; i < 4; i++)
            if (b_op0n + i < 64 && op0_t[b_op0n + i] - op0_t[b_op0n + i - 1] < mn)
                mn = op0_t[b_op0n + i] - op0_t[b_op0n + i - 1];
        `CHK("tmo_spacing", (mn >= 100), 1'b1)
        status_hang = 1'b0;

        // Lock bit never clears.
        erase_clear_at = 1000;
        snap();
        pulse_start();
        wait_end(3000);
        `CHK("lock_err", {got_err, error_code}, {1'b1, 3'd4})
        `CHK("lock_polls", op_cnt[1] - b_op[1], 8)
        erase_clear_at = 2;

        // Wrong device signature.
        id_val = 24'h1E9322;
        pulse_start();
        wait_end(3000);
        `CHK("id_err", {got_err, error_code}, {1'b1, 3'd7})
        id_val = 24'h1E9123;

        // Zero status byte.
        status_val = 8'h00;
        pulse_start();
        wait_end(3000);
        `CHK("status_err", {got_err, error_code}, {1'b1, 3'd1})
        status_val = 8'h30;

`ifdef UPDI_PROG_SEQ_VERIFY_EN
        // Read-back byte 5 of block 0 corrupted.
        corrupt = 1'b1;
        snap();
        pulse_start();
        wait_end(3000);
        `CHK("vfy_err", {got_err, error_code}, {1'b1, 3'd6})
        `CHK("vfy_after_done", op8_done_cnt - b_o8d, 1)
        `CHK("vfy_writes", op_cnt[7] - b_op[7], 1)
        corrupt = 1'b0;
`endif

        // Asynchronous reset in the middle of a block write.
        pulse_start();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (cmd_op == 4'd7 && blk_idx >= 7'd20) break;
        end
        `CHK("mid_write", {cmd_op, (blk_idx >= 7'd20)}, {4'd7, 1'b1})
        #2 rst = 1'b1;
        #1;
        `CHK("async_rst_outs", {busy, done, error, error_code, break_start, cmd_valid, blk_start,
                                cmd_op, cmd_addr, cmd_len, blk_idx}, 43'd0)
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        `CHK("post_rst_idle", {busy, cmd_valid}, 2'b00)
        snap();
        pulse_start();
        `CHK("restart_break", break_start, 1'b1)
        wait_end(3000);
        `CHK("restart_done", got_done, 1'b1)
        `CHK("restart_breaks", brk_cnt - b_brk, 1)

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
